demux_3_pingpong: RTL and testbench
===================================

Name: demux_3_pingpong

Overview:
- Inverse of the team's 3-bit 2:1 select mux. Takes one 3-bit quantizer/sample word stream and steers each word to output channel A or B.
- Routing is either direct (en selects the channel) or automatic ping-pong (alternating A, B, A, ...).
- Each output has a one-entry registered slot with valid/ready handshake and a wrap-around word counter.
- Sits between the delta-sigma quantizer word stream and two downstream consumers, e.g. per-phase filters.

Parameters:
- WIDTH, 3, data word width in bits.
- CNT_W, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts in_data this cycle.
- en  input  1  direct mode channel select: 0 -> A, 1 -> B.
- alt  input  1  1 = ping-pong mode; en is ignored.
- a_data  output  WIDTH  channel A word.
- a_valid  output  1  channel A word present.
- a_ready  input  1  channel A consumer accepts.
- b_data  output  WIDTH  channel B word.
- b_valid  output  1  channel B word present.
- b_ready  input  1  channel B consumer accepts.
- cnt_a  output  CNT_W  words delivered into slot A, modulo 2^CNT_W.
- cnt_b  output  CNT_W  words delivered into slot B, modulo 2^CNT_W.
- ptr  output  1  next ping-pong target: 0 = A, 1 = B.

Behaviour:
- Reset (rst=1 at clk edge): a_valid=b_valid=0, a_data=b_data=0, cnt_a=cnt_b=0, ptr=0. Reset applies mid-transfer; any held word is discarded.
- Target: tgt = alt ? ptr : en. Evaluated combinationally each cycle; en and alt only matter in a cycle where a transfer occurs.
- Slot X can accept: acc_X = !X_valid || X_ready.
- in_ready = acc_tgt. It is combinational from tgt, a_ready/b_ready and the valids. There is no dependence on in_valid.
- Transfer: in_valid && in_ready. At the next edge the target slot loads in_data, its valid is set to 1, and its counter increments (wraps 2^CNT_W-1 -> 0).
- If alt=1 during a transfer, ptr toggles.
- Latency: 1 cycle from accepted input to X_valid.
- Throughput: 1 word/cycle sustained while the target consumer holds ready=1.
- Slot drain: X_valid && X_ready with no load into X in the same cycle -> X_valid=0 next cycle. X_data holds its last value.
- Simultaneous drain and load of the same slot: X_valid stays 1 and X_data takes the new word (pass-through, no bubble).
- Non-target slot is unaffected by the transfer. It drains independently in the same cycle.
- Backpressure: if the target slot is full and its consumer is not ready, in_ready=0. Slot data and valid hold stable until accepted. Valid never drops without a handshake.
- Mode change: while alt=0, ptr is forced to 0 each cycle. Entering ping-pong therefore always starts at A.
- A change of en or alt while in_valid=1 and in_ready=0 is legal. The target is recomputed and the word may go to the other channel.
- No word is ever duplicated or dropped except on reset.

Decomposition:
- Package demux_pkg: default WIDTH=3, CNT_W=8, localparams CH_A=1'b0, CH_B=1'b1.
- Sub-module out_slot: one-entry register slice with load, data, valid, ready, accept-flag, plus counter. Instantiated twice, for A and B.
- Top module: target select, in_ready mux, ptr flop.

Test Plan:
- Reset then direct mode: alt=0, en=0, in_data=3'b101, in_valid=1 one cycle, a_ready=0 -> next cycle a_valid=1, a_data=101, cnt_a=1, b_valid=0. With en=1 and 3'b010 -> b_valid=1, b_data=010, cnt_b=1.
- Ping-pong: alt=1, both ready=1, stream 1,2,3,4 back-to-back -> A receives 1,3 and B receives 2,4, in_ready constantly 1, ptr toggles 0,1,0,1, cnt_a=cnt_b=2.
- Backpressure: en=0, a_ready=0, two words 6 then 7 -> 6 held in A, in_ready=0 while 7 is offered. Raise a_ready -> same cycle in_ready=1, next cycle a_data=7 with a_valid still 1. Nothing lost.
- Independent channel: A full and stalled, en=1, word 4 -> in_ready=1, B gets 4, A unchanged.
- Counter wrap: 256 transfers to A -> cnt_a returns to 0 while cnt_b stays 0.
- Mid-operation reset: rst=1 while a_valid=b_valid=1 and alt=1 with ptr=1 -> next cycle all valids 0, counters 0, ptr 0. The first post-reset ping-pong word goes to A.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared defaults and channel encodings for the 3-bit ping-pong demultiplexer.
package demux_pkg;
    localparam int   DEF_WIDTH = 3;
    localparam int   DEF_CNT_W = 8;
    localparam logic CH_A      = 1'b0;
    localparam logic CH_B      = 1'b1;
endpackage

// File: rtl/out_slot.sv
// One-entry registered output slot with valid/ready handshake and a wrap-around
// count of words loaded into it.
module out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             acc,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Empty, or the held word leaves this cycle: a new word can move in.
    assign acc = !valid_q || ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign cnt   = cnt_q;
endmodule

// File: rtl/demux_3_pingpong.sv
// Steers a word stream to channel A or B, either by en or alternating A/B,
// into two independently drained one-entry slots.
module demux_3_pingpong
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    input  logic             alt,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             ptr
);
    logic ptr_q, ptr_d;
    logic tgt, xfer, a_acc, b_acc, a_load, b_load;

    assign tgt      = alt ? ptr_q : en;
    assign in_ready = (tgt == CH_B) ? b_acc : a_acc;
    assign xfer     = in_valid && in_ready;
    assign a_load   = xfer && (tgt == CH_A);
    assign b_load   = xfer && (tgt == CH_B);

    // Outside ping-pong the pointer is parked on A so the next burst starts there.
    always_comb begin
        ptr_d = CH_A;
        if (alt) begin
            ptr_d = xfer ? ~ptr_q : ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= CH_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

    out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .load      (a_load),
        .load_data (in_data),
        .ready     (a_ready),
        .acc       (a_acc),
        .data      (a_data),
        .valid     (a_valid),
        .cnt       (cnt_a)
    );

    out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .load      (b_load),
        .load_data (in_data),
        .ready     (b_ready),
        .acc       (b_acc),
        .data      (b_data),
        .valid     (b_valid),
        .cnt       (cnt_b)
    );
endmodule

// File: tb/tb_demux_3_pingpong.sv
// Bench for demux_3_pingpong: directed vector table, hand sequences for counter
// wrap and mid-stream reset, then random traffic against a channel-level model.
module tb_demux_3_pingpong;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       en;
    logic       alt;
    logic [2:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [2:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic       ptr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_3_pingpong dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .en       (en),
        .alt      (alt),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .ptr      (ptr)
    );

    typedef struct {
        int iv, d, en, alt, ar, br;
        int rdy;
        int av, ad, bv, bd, ca, cb, p;
    } vec_t;

    vec_t tbl[21];

    // Channel-level reference: slot contents indexed by channel (0 = A, 1 = B).
    int m_valid[2];
    int m_data[2];
    int m_cnt[2];
    int m_ptr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int r, input int iv, input int d, input int e,
                         input int al, input int ar, input int br);
        rst      = r[0];
        in_valid = iv[0];
        in_data  = d[2:0];
        en       = e[0];
        alt      = al[0];
        a_ready  = ar[0];
        b_ready  = br[0];
    endtask

    task automatic chk_state(input string tag, input int av, input int ad, input int bv,
                             input int bd, input int ca, input int cb, input int p);
        chk({tag, ".a_valid"}, int'(a_valid), av);
        chk({tag, ".a_data"},  int'(a_data),  ad);
        chk({tag, ".b_valid"}, int'(b_valid), bv);
        chk({tag, ".b_data"},  int'(b_data),  bd);
        chk({tag, ".cnt_a"},   int'(cnt_a),   ca);
        chk({tag, ".cnt_b"},   int'(cnt_b),   cb);
        chk({tag, ".ptr"},     int'(ptr),     p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int model_ready(input int iv, input int e, input int al,
                                       input int ar, input int br);
        int t;
        int rdy_ch[2];
        t = al ? m_ptr : e;
        rdy_ch[0] = (!m_valid[0] || ar) ? 1 : 0;
        rdy_ch[1] = (!m_valid[1] || br) ? 1 : 0;
        return rdy_ch[t];
    endfunction

    task automatic model_edge(input int r, input int iv, input int d, input int e,
                              input int al, input int ar, input int br);
        int t;
        int ready_ch[2];
        int go;
        if (r) begin
            for (int c = 0; c < 2; c++) begin
                m_valid[c] = 0;
                m_data[c]  = 0;
                m_cnt[c]   = 0;
            end
            m_ptr = 0;
        end else begin
            t = al ? m_ptr : e;
            ready_ch[0] = ar;
            ready_ch[1] = br;
            go = iv && model_ready(iv, e, al, ar, br);
            for (int c = 0; c < 2; c++) begin
                if (go && c == t) begin
                    m_valid[c] = 1;
                    m_data[c]  = d;
                    m_cnt[c]   = (m_cnt[c] + 1) % 256;
                end else if (m_valid[c] && ready_ch[c]) begin
                    m_valid[c] = 0;
                end
            end
            if (!al) m_ptr = 0;
            else if (go) m_ptr = 1 - m_ptr;
        end
    endtask

    initial begin
        int r, iv, d, e, al, ar, br, er;

        // iv d en alt ar br | rdy | av ad bv bd ca cb ptr
        tbl[0]  = '{1, 5, 0, 0, 0, 0, 1, 1, 5, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 2, 1, 0, 0, 0, 1, 1, 5, 1, 2, 1, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 1, 1, 0, 5, 0, 2, 1, 1, 0};
        tbl[3]  = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 2, 2, 1, 1};
        tbl[4]  = '{1, 2, 0, 1, 1, 1, 1, 0, 1, 1, 2, 2, 2, 0};
        tbl[5]  = '{1, 3, 0, 1, 1, 1, 1, 1, 3, 0, 2, 3, 2, 1};
        tbl[6]  = '{1, 4, 0, 1, 1, 1, 1, 0, 3, 1, 4, 3, 3, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 1, 1, 0, 3, 0, 4, 3, 3, 0};
        tbl[8]  = '{1, 6, 0, 0, 0, 0, 1, 1, 6, 0, 4, 4, 3, 0};
        tbl[9]  = '{1, 7, 0, 0, 0, 0, 0, 1, 6, 0, 4, 4, 3, 0};
        tbl[10] = '{1, 7, 0, 0, 0, 0, 0, 1, 6, 0, 4, 4, 3, 0};
        tbl[11] = '{1, 7, 0, 0, 1, 0, 1, 1, 7, 0, 4, 5, 3, 0};
        tbl[12] = '{1, 4, 1, 0, 0, 0, 1, 1, 7, 1, 4, 5, 4, 0};
        tbl[13] = '{1, 3, 0, 0, 0, 1, 0, 1, 7, 0, 4, 5, 4, 0};
        tbl[14] = '{1, 3, 1, 0, 0, 0, 1, 1, 7, 1, 3, 5, 5, 0};
        tbl[15] = '{0, 0, 0, 0, 1, 1, 1, 0, 7, 0, 3, 5, 5, 0};
        tbl[16] = '{1, 5, 0, 1, 0, 0, 1, 1, 5, 0, 3, 6, 5, 1};
        tbl[17] = '{1, 6, 0, 1, 0, 0, 1, 1, 5, 1, 6, 6, 6, 0};
        tbl[18] = '{1, 1, 0, 1, 0, 0, 0, 1, 5, 1, 6, 6, 6, 0};
        tbl[19] = '{1, 1, 1, 0, 0, 0, 0, 1, 5, 1, 6, 6, 6, 0};
        tbl[20] = '{0, 0, 0, 0, 1, 1, 1, 0, 5, 0, 6, 6, 6, 0};

        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(0, tbl[i].iv, tbl[i].d, tbl[i].en, tbl[i].alt, tbl[i].ar, tbl[i].br);
            #1;
            chk($sformatf("vec%0d.in_ready", i), int'(in_ready), tbl[i].rdy);
            @(posedge clk);
            #1;
            chk_state($sformatf("vec%0d", i), tbl[i].av, tbl[i].ad, tbl[i].bv,
                      tbl[i].bd, tbl[i].ca, tbl[i].cb, tbl[i].p);
        end

        // 256 words into A: counter wraps back to zero, B untouched.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            drive(0, 1, i % 8, 0, 0, 1, 0);
            #1;
            chk("wrap.in_ready", int'(in_ready), 1);
            @(posedge clk);
            #1;
            if (i == 254) chk("wrap.cnt_a_255", int'(cnt_a), 255);
        end
        chk("wrap.cnt_a_0", int'(cnt_a), 0);
        chk("wrap.cnt_b", int'(cnt_b), 0);
        chk("wrap.a_data", int'(a_data), 7);
        chk("wrap.a_valid", int'(a_valid), 1);

        // Fill both slots in ping-pong leaving ptr on B, then reset mid-stream.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 1, i + 1, 0, 1, 1, 0);
            @(posedge clk);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        chk_state("pre_rst", 1, 3, 1, 2, 2, 1, 1);
        drive(1, 1, 6, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk_state("mid_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 5, 1, 1, 0, 0);
        #1;
        chk("post_rst.in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        chk_state("post_rst", 1, 5, 0, 0, 1, 0, 1);

        // Random traffic against the reference model.
        do_reset();
        model_edge(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) == 0) ? 1 : 0;
            iv = ($urandom_range(0, 3) != 0) ? 1 : 0;
            d  = int'($urandom_range(0, 7));
            e  = int'($urandom_range(0, 1));
            al = ($urandom_range(0, 7) < 5) ? 1 : 0;
            ar = ($urandom_range(0, 2) != 0) ? 1 : 0;
            br = ($urandom_range(0, 2) != 0) ? 1 : 0;
            @(negedge clk);
            drive(r, iv, d, e, al, ar, br);
            #1;
            if (!r) begin
                er = model_ready(iv, e, al, ar, br);
                if (int'(in_ready) != er) chk("rand.in_ready", int'(in_ready), er);
                else checks++;
            end
            @(posedge clk);
            model_edge(r, iv, d, e, al, ar, br);
            #1;
            if (int'(a_valid) != m_valid[0] || int'(b_valid) != m_valid[1] ||
                int'(a_data) != m_data[0] || int'(b_data) != m_data[1] ||
                int'(cnt_a) != m_cnt[0] || int'(cnt_b) != m_cnt[1] || int'(ptr) != m_ptr) begin
                chk_state($sformatf("rand%0d", i), m_valid[0], m_data[0], m_valid[1],
                          m_data[1], m_cnt[0], m_cnt[1], m_ptr);
            end else begin
                checks++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
